// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: measures line timing, locks onto a stable line length and
// forwards active pixels with their coordinates once locked.
module vga_rx_monitor #(
   parameter int unsigned H_MAX = 2047,
   parameter int unsigned V_MAX = 2047
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_px_en,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_blank,
   input  logic [7:0]  i_red,
   input  logic [7:0]  i_grn,
   input  logic [7:0]  i_blu,
   output logic        o_pix_valid,
   output logic [23:0] o_pix_rgb,
   output logic [10:0] o_x,
   output logic [10:0] o_y,
   output logic        o_frame_start,
   output logic [10:0] o_line_len,
   output logic [10:0] o_act_lines,
   output logic        o_locked,
   output logic        o_err
);

   localparam logic [10:0] HMax = 11'(H_MAX);
   localparam logic [10:0] VMax = 11'(V_MAX);

   typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

   state_e      r_state, w_state_nxt;
   logic        r_hs_prev, r_vs_prev;
   logic [10:0] r_h_cnt;
   logic        r_h_valid;
   logic [10:0] r_x, r_y;
   logic        r_line_act;
   logic [10:0] r_ref_len, w_ref_len_d;
   logic [10:0] r_act_lines;
   logic        r_pix_valid;
   logic [23:0] r_pix_rgb;
   logic [10:0] r_pix_x, r_pix_y;
   logic        r_frame_start, r_err;

   logic        w_h_fall, w_v_fall, w_len_chk, w_pix_ok;
   logic        w_line_err, w_frame_err, w_act_upd;
   logic [10:0] w_x_cur, w_y_inc, w_y_cur;

   assign w_h_fall  = i_px_en & r_hs_prev & ~i_hsync;
   assign w_v_fall  = i_px_en & r_vs_prev & ~i_vsync;
   // The first line after reset started at an unknown point and is never measured.
   assign w_len_chk = w_h_fall & r_h_valid;
   assign w_x_cur   = w_h_fall ? 11'd0 : r_x;
   // Line count including a line that ends on this very strobe.
   assign w_y_inc   = (w_h_fall && r_line_act && r_y != VMax) ? r_y + 11'd1 : r_y;
   assign w_y_cur   = w_v_fall ? 11'd0 : w_y_inc;
   assign w_pix_ok  = i_px_en & ~i_blank & (r_state == StLocked);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= StSearch;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ref_len_d = r_ref_len;
      w_line_err  = 1'b0;
      w_frame_err = 1'b0;
      w_act_upd   = 1'b0;
      unique case (r_state)
         StSearch: begin
            w_ref_len_d = 11'd0;
            if (w_v_fall) w_state_nxt = StMeasure;
         end
         StMeasure: begin
            if (w_len_chk) begin
               if (r_ref_len != 11'd0 && r_h_cnt == r_ref_len) w_state_nxt = StLocked;
               else                                           w_ref_len_d = r_h_cnt;
            end
         end
         StLocked: begin
            if (w_len_chk && r_h_cnt != r_ref_len) begin
               w_line_err  = 1'b1;
               w_state_nxt = StSearch;
            end
            if (w_v_fall && w_y_inc != r_act_lines) begin
               w_act_upd   = 1'b1;
               w_frame_err = (r_act_lines != 11'd0);
            end
         end
         default: w_state_nxt = StSearch;
      endcase
   end

   always_comb begin
      o_locked   = (r_state == StLocked);
      o_line_len = (r_state == StSearch) ? 11'd0 : r_ref_len;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_hs_prev     <= 1'b1;
         r_vs_prev     <= 1'b1;
         r_h_cnt       <= '0;
         r_h_valid     <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_line_act    <= 1'b0;
         r_ref_len     <= '0;
         r_act_lines   <= '0;
         r_pix_valid   <= 1'b0;
         r_pix_rgb     <= '0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_frame_start <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_pix_valid   <= w_pix_ok;
         r_pix_rgb     <= w_pix_ok ? {i_red, i_grn, i_blu} : 24'd0;
         r_pix_x       <= w_pix_ok ? w_x_cur : 11'd0;
         r_pix_y       <= w_pix_ok ? w_y_cur : 11'd0;
         r_frame_start <= w_v_fall;
         r_err         <= w_line_err | w_frame_err;
         r_ref_len     <= w_ref_len_d;
         if (w_act_upd) r_act_lines <= w_y_inc;
         if (i_px_en) begin
            r_hs_prev  <= i_hsync;
            r_vs_prev  <= i_vsync;
            r_h_cnt    <= w_h_fall ? 11'd1 : ((r_h_cnt == HMax) ? r_h_cnt : r_h_cnt + 11'd1);
            if (w_h_fall) r_h_valid <= 1'b1;
            r_x        <= (!i_blank && w_x_cur != HMax) ? w_x_cur + 11'd1 : w_x_cur;
            r_y        <= w_y_cur;
            r_line_act <= (w_h_fall ? 1'b0 : r_line_act) | ~i_blank;
         end
      end
   end

   assign o_pix_valid   = r_pix_valid;
   assign o_pix_rgb     = r_pix_rgb;
   assign o_x           = r_pix_x;
   assign o_y           = r_pix_y;
   assign o_frame_start = r_frame_start;
   assign o_act_lines   = r_act_lines;
   assign o_err         = r_err;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced raster: 20 strobes/line (12 active from
// column 4), 12 lines/frame (8 active from row 4), vsync low on rows 0-1.
module tb_vga_rx_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        px_en, hsync, vsync, blank;
   logic [7:0]  red, grn, blu;
   logic        pix_valid, frame_start, locked, err;
   logic [23:0] pix_rgb;
   logic [10:0] x, y, line_len, act_lines;

   int n_cmp = 0;
   int n_mis = 0;
   int gap = 4;
   int probe_row = -1;
   int pix_cnt = 0;
   int sat_cnt = 0;
   int err_cnt = 0;
   int fs_cnt = 0;
   int last_x = 0;
   int last_y = 0;
   int mark;

   vga_rx_monitor dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_px_en       (px_en),
      .i_hsync       (hsync),
      .i_vsync       (vsync),
      .i_blank       (blank),
      .i_red         (red),
      .i_grn         (grn),
      .i_blu         (blu),
      .o_pix_valid   (pix_valid),
      .o_pix_rgb     (pix_rgb),
      .o_x           (x),
      .o_y           (y),
      .o_frame_start (frame_start),
      .o_line_len    (line_len),
      .o_act_lines   (act_lines),
      .o_locked      (locked),
      .o_err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pix_valid) begin
         pix_cnt++;
         last_x = int'(x);
         last_y = int'(y);
         if (x == 11'd2047) sat_cnt++;
      end
      if (err) err_cnt++;
      if (frame_start) fs_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check_eq({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
      check_eq({tag, "_x"}, 32'(x), 32'd0);
      check_eq({tag, "_y"}, 32'(y), 32'd0);
      check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      check_eq({tag, "_line_len"}, 32'(line_len), 32'd0);
      check_eq({tag, "_act_lines"}, 32'(act_lines), 32'd0);
      check_eq({tag, "_locked"}, 32'(locked), 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic strobe(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
      for (int i = 1; i < gap; i++) begin
         @(posedge clk);
         #1;
      end
      px_en = 1'b1;
      hsync = hs;
      vsync = vs;
      blank = bl;
      {red, grn, blu} = rgb;
      @(posedge clk);
      #1;
      px_en = 1'b0;
   endtask

   task automatic send_line(input int row, input int len, input int act_rows);
      logic        act;
      logic        bl;
      logic [23:0] rgb;
      act = (row >= 4) && (row < 4 + act_rows);
      for (int c = 0; c < len; c++) begin
         bl  = !(act && c >= 4 && c < 16);
         rgb = {c[7:0], row[7:0], 8'h3C};
         if (row == probe_row && c == 15) rgb = 24'hA55AFF;
         strobe(c >= 2, row >= 2, bl, rgb);
         if (row == probe_row && c == 15) begin
            check_eq("probe_valid", 32'(pix_valid), 32'd1);
            check_eq("probe_x", 32'(x), 32'd11);
            check_eq("probe_y", 32'(y), 32'd7);
            check_eq("probe_rgb", 32'(pix_rgb), 32'h00A55AFF);
            @(posedge clk);
            #1;
            check_eq("probe_one_cycle", 32'(pix_valid), 32'd0);
         end
      end
   endtask

   task automatic send_rows(input int from, input int to, input int act_rows, input int short_row);
      for (int r = from; r <= to; r++) send_line(r, (r == short_row) ? 19 : 20, act_rows);
   endtask

   task automatic long_line(input logic first, input logic act);
      for (int c = 0; c < 3000; c++) strobe(c != 0, !(first && c == 0), !act, 24'h123456);
   endtask

   initial begin
      rst   = 1'b0;
      px_en = 1'b0;
      hsync = 1'b1;
      vsync = 1'b1;
      blank = 1'b1;
      {red, grn, blu} = 24'd0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Frame 1: measure on rows 0-1, lock at start of row 2.
      send_rows(0, 1, 8, -1);
      check_eq("f1_ref_len", 32'(line_len), 32'd20);
      check_eq("f1_not_locked_yet", 32'(locked), 32'd0);
      send_rows(2, 11, 8, -1);
      check_eq("f1_locked", 32'(locked), 32'd1);
      check_eq("f1_pix_cnt", 32'(pix_cnt), 32'd96);
      check_eq("f1_act_lines", 32'(act_lines), 32'd0);

      // Frame 2: probe the last pixel; act_lines captured at its vsync edge.
      probe_row = 11;
      send_rows(0, 11, 8, -1);
      probe_row = -1;
      check_eq("f2_act_lines", 32'(act_lines), 32'd8);
      check_eq("f2_fs_cnt", 32'(fs_cnt), 32'd2);
      check_eq("f2_pix_cnt", 32'(pix_cnt), 32'd192);
      check_eq("f2_err_cnt", 32'(err_cnt), 32'd0);

      // Frame 3: only 7 active rows.
      send_rows(0, 11, 7, -1);
      check_eq("f3_pix_cnt", 32'(pix_cnt), 32'd276);

      // Frame 4 start: active-line mismatch, stays locked; then a 19-strobe line drops lock.
      send_rows(0, 0, 8, 5);
      check_eq("f4_act_err_cnt", 32'(err_cnt), 32'd1);
      check_eq("f4_act_lines", 32'(act_lines), 32'd7);
      check_eq("f4_still_locked", 32'(locked), 32'd1);
      send_rows(1, 11, 8, 5);
      check_eq("f4_short_err_cnt", 32'(err_cnt), 32'd2);
      check_eq("f4_unlocked", 32'(locked), 32'd0);
      check_eq("f4_line_len_search", 32'(line_len), 32'd0);
      check_eq("f4_pix_cnt", 32'(pix_cnt), 32'd300);

      // Frame 5: relock after vsync plus two equal lines.
      send_rows(0, 1, 8, -1);
      check_eq("f5_not_locked_yet", 32'(locked), 32'd0);
      check_eq("f5_ref_len", 32'(line_len), 32'd20);
      send_rows(2, 11, 8, -1);
      check_eq("f5_relocked", 32'(locked), 32'd1);
      check_eq("f5_pix_cnt", 32'(pix_cnt), 32'd396);

      // Frame 6: 8 lines vs stored 7 gives an error, then reset mid row 6.
      send_rows(0, 5, 8, -1);
      check_eq("f6_err_cnt", 32'(err_cnt), 32'd3);
      check_eq("f6_act_lines", 32'(act_lines), 32'd8);
      send_line(6, 10, 8);
      @(negedge clk);
      #1;
      check_eq("pre_rst_pix_cnt", 32'(pix_cnt), 32'd426);
      rst = 1'b0;
      #1;
      check_idle("midrst");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send_rows(7, 11, 8, -1);
      check_eq("postrst_no_pix", 32'(pix_cnt), 32'd426);
      check_eq("postrst_unlocked", 32'(locked), 32'd0);
      send_rows(0, 11, 8, -1);
      check_eq("f7_locked", 32'(locked), 32'd1);
      check_eq("f7_pix_cnt", 32'(pix_cnt), 32'd522);
      send_rows(0, 0, 8, -1);
      check_eq("f8_act_lines", 32'(act_lines), 32'd8);
      check_eq("f8_err_cnt", 32'(err_cnt), 32'd3);
      check_eq("f8_fs_cnt", 32'(fs_cnt), 32'd8);

      // Saturation: 3000-strobe lines with a strobe every clock.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      hsync = 1'b1;
      vsync = 1'b1;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      gap = 1;
      long_line(1'b1, 1'b0);
      long_line(1'b0, 1'b0);
      check_eq("sat_ref_len", 32'(line_len), 32'd2047);
      check_eq("sat_measure", 32'(locked), 32'd0);
      long_line(1'b0, 1'b0);
      check_eq("sat_locked", 32'(locked), 32'd1);
      mark = pix_cnt;
      long_line(1'b0, 1'b1);
      strobe(1'b0, 1'b1, 1'b1, 24'd0);
      check_eq("sat_pix_cnt", 32'(pix_cnt - mark), 32'd3000);
      check_eq("sat_x_at_max", 32'(sat_cnt), 32'd953);
      check_eq("sat_last_x", 32'(last_x), 32'd2047);
      check_eq("sat_last_y", 32'(last_y), 32'd0);
      check_eq("sat_still_locked", 32'(locked), 32'd1);
      check_eq("sat_err_cnt", 32'(err_cnt), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
